// File: rtl/bif_sync_pkg.sv
// Shared defaults, channel output bundle and elaboration helpers for the BIF synchroniser.
// Optional glitch filter is built only when BIF_SYNC_FILTER_EN is defined.
package bif_sync_pkg;

    localparam int unsigned BIF_SYNC_CH    = 10;
    localparam int unsigned BIF_SYNC_DEPTH = 3;
    localparam int unsigned BIF_SYNC_FILT  = 2;

    typedef struct packed {
        logic flt_n;
        logic fall;
        logic rise;
        logic stky;
    } bif_chan_out_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((result < 32) && ((64'd1 << result) < 64'(value))) begin
            result++;
        end
        return result;
    endfunction

    function automatic bit ch_ok(input int unsigned ch);
        return ch >= 1;
    endfunction

    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= 2) && (depth <= 8);
    endfunction

    function automatic bit filt_ok(input int unsigned filt);
        return (filt >= 1) && (filt <= 15);
    endfunction

endpackage

// File: rtl/bif_sync_filter_if.sv
// Bus-side bundle of the BIF synchroniser: raw inputs, taps, filtered level, edges and sticky flags.
interface bif_sync_filter_if #(
    parameter int unsigned CH    = 10,
    parameter int unsigned DEPTH = 3
);
    logic [CH-1:0]       IN_n;
    logic [DEPTH*CH-1:0] TAP_n;
    logic [CH-1:0]       FLT_n;
    logic [CH-1:0]       FALL;
    logic [CH-1:0]       RISE;
    logic [CH-1:0]       STKY;
    logic [CH-1:0]       STKY_CLR;

    modport master (
        output IN_n,
        output STKY_CLR,
        input  TAP_n,
        input  FLT_n,
        input  FALL,
        input  RISE,
        input  STKY
    );

    modport slave (
        input  IN_n,
        input  STKY_CLR,
        output TAP_n,
        output FLT_n,
        output FALL,
        output RISE,
        output STKY
    );
endinterface

// File: rtl/bif_sync_chan.sv
// One BIF channel: synchroniser chain, optional glitch filter (BIF_SYNC_FILTER_EN),
// registered edge pulses and sticky fall flag.
module bif_sync_chan
    import bif_sync_pkg::*;
#(
    parameter int unsigned DEPTH   = BIF_SYNC_DEPTH,
    parameter int unsigned FILT    = BIF_SYNC_FILT,
    parameter bit          RST_VAL = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_n_i,
    input  logic             stky_clr_i,
    output logic [DEPTH-1:0] tap_n_o,
    output bif_chan_out_t    chan_o
);

    if (!depth_ok(DEPTH) || !filt_ok(FILT)) begin : g_bad_param
        $error("bif_sync_chan: DEPTH must be 2..8 and FILT 1..15");
    end

    logic [DEPTH-1:0] stage_q, stage_d;
    logic             flt_q, flt_d;
    logic             fall_q, fall_d;
    logic             rise_q, rise_d;
    logic             stky_q, stky_d;
    logic             last;

    assign last = stage_q[DEPTH-1];

    always_comb begin
        stage_d = {stage_q[DEPTH-2:0], in_n_i};
    end

`ifdef BIF_SYNC_FILTER_EN
    localparam int unsigned CntW = clog2(FILT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Count restarts whenever the last stage agrees with the filtered level again.
    always_comb begin
        cnt_d = '0;
        flt_d = flt_q;
        if (last != flt_q) begin
            if (cnt_q == CntW'(FILT - 1)) begin
                flt_d = last;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        flt_d = last;
    end
`endif

    always_comb begin
        fall_d = flt_q & ~flt_d;
        rise_d = ~flt_q & flt_d;
        stky_d = fall_q | (stky_q & ~stky_clr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= {DEPTH{RST_VAL}};
            flt_q   <= RST_VAL;
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
            stky_q  <= 1'b0;
        end else begin
            stage_q <= stage_d;
            flt_q   <= flt_d;
            fall_q  <= fall_d;
            rise_q  <= rise_d;
            stky_q  <= stky_d;
        end
    end

    assign tap_n_o      = stage_q;
    assign chan_o.flt_n = flt_q;
    assign chan_o.fall  = fall_q;
    assign chan_o.rise  = rise_q;
    assign chan_o.stky  = stky_q;

endmodule

// File: rtl/bif_sync_filter.sv
// CH-channel BIF input synchroniser with taps, glitch filter (BIF_SYNC_FILTER_EN), edges, sticky.
// Stage k of every channel is packed at TAP_n[k*CH +: CH].
module bif_sync_filter
    import bif_sync_pkg::*;
#(
    parameter int unsigned    CH      = BIF_SYNC_CH,
    parameter int unsigned    DEPTH   = BIF_SYNC_DEPTH,
    parameter int unsigned    FILT    = BIF_SYNC_FILT,
    parameter logic [CH-1:0]  RST_VAL = '1
) (
    input logic              OSC,
    input logic              CLEAR,
    bif_sync_filter_if.slave bus
);

    if (!ch_ok(CH)) begin : g_bad_ch
        $error("bif_sync_filter: CH must be at least 1");
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        logic [DEPTH-1:0] tap_n;
        bif_chan_out_t    chan_out;

        bif_sync_chan #(
            .DEPTH   (DEPTH),
            .FILT    (FILT),
            .RST_VAL (RST_VAL[i])
        ) u_chan (
            .clk_i      (OSC),
            .rst_i      (CLEAR),
            .in_n_i     (bus.IN_n[i]),
            .stky_clr_i (bus.STKY_CLR[i]),
            .tap_n_o    (tap_n),
            .chan_o     (chan_out)
        );

        assign bus.FLT_n[i] = chan_out.flt_n;
        assign bus.FALL[i]  = chan_out.fall;
        assign bus.RISE[i]  = chan_out.rise;
        assign bus.STKY[i]  = chan_out.stky;

        for (genvar k = 0; k < DEPTH; k++) begin : g_tap
            assign bus.TAP_n[k*CH + i] = tap_n[k];
        end
    end

endmodule

// File: tb/tb_bif_sync_filter.sv
// Bench for bif_sync_filter: input-history model checked every cycle plus directed literal checks.
module tb_bif_sync_filter;

    localparam int CH    = 10;
    localparam int DEPTH = 3;
    localparam int FILT  = 2;
`ifdef BIF_SYNC_FILTER_EN
    localparam int EFF_F   = FILT;
    localparam int LAT     = 5;
    localparam int GL_EDGE = 0;
`else
    localparam int EFF_F   = 1;
    localparam int LAT     = 4;
    localparam int GL_EDGE = 1;
`endif
    localparam logic [CH-1:0] ONES = '1;

    logic OSC   = 1'b0;
    logic CLEAR = 1'b0;

    bif_sync_filter_if #(.CH(CH), .DEPTH(DEPTH)) bus ();

    bif_sync_filter #(
        .CH      (CH),
        .DEPTH   (DEPTH),
        .FILT    (FILT),
        .RST_VAL (ONES)
    ) dut (
        .OSC   (OSC),
        .CLEAR (CLEAR),
        .bus   (bus)
    );

    always #5 OSC = ~OSC;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every input word captured since reset release; all outputs derive from that history.
    logic [CH-1:0] hist[$];
    int            e      = 0;
    logic [CH-1:0] m_flt  = ONES;
    logic [CH-1:0] m_fall = '0;
    logic [CH-1:0] m_rise = '0;
    logic [CH-1:0] m_stky = '0;

    function automatic logic [CH-1:0] hist_at(input int n);
        if (n < 1) return ONES;
        return hist[n-1];
    endfunction

    function automatic logic [DEPTH*CH-1:0] model_tap();
        logic [DEPTH*CH-1:0] t;
        for (int k = 0; k < DEPTH; k++) t[k*CH +: CH] = hist_at(e - k);
        return t;
    endfunction

    initial forever begin
        logic [CH-1:0] nf;
        logic [CH-1:0] l;
        bit            flip;
        @(posedge OSC or posedge CLEAR);
        if (CLEAR) begin
            hist.delete();
            e      = 0;
            m_flt  = ONES;
            m_fall = '0;
            m_rise = '0;
            m_stky = '0;
        end else begin
            hist.push_back(bus.IN_n);
            e++;
            m_stky = m_fall | (m_stky & ~bus.STKY_CLR);
            nf = m_flt;
            // Flip when the last stage disagreed with the level on each of the last EFF_F edges.
            for (int i = 0; i < CH; i++) begin
                flip = (e - EFF_F + 1 >= 1);
                for (int j = 0; j < EFF_F; j++) begin
                    l = hist_at(e - j - DEPTH);
                    if (l[i] == m_flt[i]) flip = 1'b0;
                end
                if (flip) nf[i] = ~m_flt[i];
            end
            m_fall = m_flt & ~nf;
            m_rise = ~m_flt & nf;
            m_flt  = nf;
        end
    end

    bit cmp_en = 1'b0;

    initial forever begin
        @(negedge OSC);
        if (cmp_en) begin
            chk("model_tap", bus.TAP_n, model_tap());
            chk("model_flt", bus.FLT_n, m_flt);
            chk("model_fall", bus.FALL, m_fall);
            chk("model_rise", bus.RISE, m_rise);
            chk("model_stky", bus.STKY, m_stky);
        end
    end

    task automatic tick();
        @(posedge OSC);
        #1;
    endtask

    task automatic pulse_ch0(input int width, output int fall_cyc, output int rise_cyc,
                             output int low_cyc);
        fall_cyc = 0;
        rise_cyc = 0;
        low_cyc  = 0;
        bus.IN_n[0] = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (n == width) bus.IN_n[0] = 1'b1;
            if (bus.FALL[0] === 1'b1) fall_cyc++;
            if (bus.RISE[0] === 1'b1) rise_cyc++;
            if (bus.FLT_n[0] === 1'b0) low_cyc++;
        end
    endtask

    initial begin
        int            fc, rc, lc;
        logic [CH-1:0] edges;

        bus.IN_n     = ONES;
        bus.STKY_CLR = '0;
        #1 CLEAR = 1'b1;
        #2;
        chk("rst_flt", bus.FLT_n, 10'h3FF);
        chk("rst_tap", bus.TAP_n, 30'h3FFF_FFFF);
        chk("rst_stky", bus.STKY, 0);
        cmp_en = 1'b1;
        tick();
        tick();
        CLEAR = 1'b0;

        // Idle after release: nothing moves.
        edges = '0;
        repeat (20) begin
            tick();
            edges = edges | bus.FALL | bus.RISE;
        end
        chk("idle_flt", bus.FLT_n, 10'h3FF);
        chk("idle_edges", edges, 0);
        chk("idle_stky", bus.STKY, 0);

        // Channel 3 asserts and holds.
        bus.IN_n[3] = 1'b0;
        for (int n = 1; n <= LAT + 1; n++) begin
            tick();
            if (n == 1) begin
                chk("tap0_b3", bus.TAP_n[3], 0);
                chk("tap2_b3_early", bus.TAP_n[2*CH + 3], 1);
            end
            if (n == 3) chk("tap2_b3", bus.TAP_n[2*CH + 3], 0);
            if (n == LAT - 1) chk("flt3_early", bus.FLT_n[3], 1);
            if (n == LAT) begin
                chk("flt3_low", bus.FLT_n[3], 0);
                chk("fall3", bus.FALL, 10'h008);
                chk("stky3_early", bus.STKY[3], 0);
            end
            if (n == LAT + 1) begin
                chk("fall3_one_cycle", bus.FALL, 0);
                chk("stky3_set", bus.STKY[3], 1);
            end
        end

        // Plain clear, then clear coinciding with a new fall.
        bus.STKY_CLR[3] = 1'b1;
        tick();
        bus.STKY_CLR[3] = 1'b0;
        chk("stky3_cleared", bus.STKY[3], 0);
        bus.IN_n[3] = 1'b1;
        repeat (LAT + 3) tick();
        bus.IN_n[3]     = 1'b0;
        bus.STKY_CLR[3] = 1'b1;
        repeat (LAT) tick();
        chk("fall3_again", bus.FALL[3], 1);
        chk("stky3_held_clr", bus.STKY[3], 0);
        tick();
        chk("stky3_set_wins", bus.STKY[3], 1);
        tick();
        chk("stky3_clr_after", bus.STKY[3], 0);
        bus.STKY_CLR[3] = 1'b0;

        // Glitches on channel 0.
        pulse_ch0(1, fc, rc, lc);
        chk("glitch1_fall", fc, GL_EDGE);
        chk("glitch1_rise", rc, GL_EDGE);
        chk("glitch1_low", lc, GL_EDGE);
        pulse_ch0(2, fc, rc, lc);
        chk("pulse2_fall", fc, 1);
        chk("pulse2_rise", rc, 1);
        chk("pulse2_low", lc, 2);

        // Reset in the middle of a channel 5 count.
        bus.IN_n[5] = 1'b0;
        repeat (DEPTH + 1) tick();
        #2 CLEAR = 1'b1;
        #1;
        chk("clr_async_flt", bus.FLT_n, 10'h3FF);
        chk("clr_async_tap", bus.TAP_n, 30'h3FFF_FFFF);
        chk("clr_async_fall", bus.FALL, 0);
        chk("clr_async_rise", bus.RISE, 0);
        chk("clr_async_stky", bus.STKY, 0);
        tick();
        CLEAR = 1'b0;
        edges = '0;
        for (int n = 1; n <= LAT; n++) begin
            tick();
            if (n < LAT) edges = edges | bus.FALL | bus.RISE;
            if (n == LAT - 1) chk("rel_flt_early", bus.FLT_n, 10'h3FF);
            if (n == LAT) begin
                chk("rel_no_early_edge", edges, 0);
                chk("rel_flt", bus.FLT_n, 10'h3D7);
                chk("rel_fall", bus.FALL, 10'h028);
            end
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
